imem_loader: RTL and testbench

Program loader for the instruction memory: receives a byte stream over a valid/ready handshake, packs it into little-endian 32-bit words, and writes them through the memory's write port starting at word 0. Holds the core in reset until a complete, checksum-verified image is in memory, then releases it. Sits between the host byte link (UART receiver or testbench) and the instruction memory write port / core reset tree.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_byte_packer.sv | 43 ++++
 rtl/imem_loader.sv | 150 +++++++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states,
// stream framing constants and the length check.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int DEPTH_DEFAULT = 32;
    localparam int LEN_MIN       = 1;
    localparam int BYTES_PER_WORD = 4;

    // A length byte is usable when it names 1..depth words.
    function automatic logic len_ok(input logic [7:0] len, input int depth);
        return (int'(len) >= LEN_MIN) && (int'(len) <= depth);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = the loader side, slave = host link / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 5
) ();
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_byte_packer.sv
// Collects four stream bytes into a little-endian 32-bit word. The word is
// presented combinationally together with word_valid_o on the fourth byte,
// so the caller can register it in the same cycle the last byte arrives.
module imem_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);
    logic [1:0]  lane_q, lane_d;
    logic [23:0] shift_q, shift_d;

    // Next lane / shift contents: new bytes enter at the top so that after
    // three pushes shift_q holds {b2, b1, b0}.
    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        if (clear_i) begin
            lane_d = 2'd0;
        end else if (push_i) begin
            lane_d  = lane_q + 2'd1;
            shift_d = {byte_i, shift_q[23:8]};
        end
    end

    // Lane counter and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q  <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

    assign word_valid_o = push_i && (lane_q == 2'd3);
    assign word_o       = {byte_i, shift_q};

endmodule

// File: rtl/imem_loader.sv
// Program loader: receives LEN, N*4 data bytes and an XOR checksum over a
// valid/ready byte stream, writes the packed words to instruction memory
// from word 0 upward and releases the core reset only after the checksum
// matches. All outputs are registered.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.master     bus,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              rx_ready_q, rx_ready_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_reset_q, cpu_reset_d;

    logic              xfer;
    logic [ADDR_W:0]   cnt_inc;
    logic              pk_clear;
    logic              pk_push;
    logic              pk_word_valid;
    logic [31:0]       pk_word;

    assign xfer     = bus.rx_valid && rx_ready_q;
    assign cnt_inc  = cnt_q + 1'b1;
    // The lane counter restarts on every length byte; a bad length sends the
    // FSM to ERR anyway, so clearing unconditionally is harmless.
    assign pk_clear = xfer && (state_q == ST_LEN);
    assign pk_push  = xfer && (state_q == ST_DATA);

    imem_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (pk_clear),
        .push_i       (pk_push),
        .byte_i       (bus.rx_data),
        .word_valid_o (pk_word_valid),
        .word_o       (pk_word)
    );

    // Next-state logic for the FSM, word counter, checksum and write port;
    // registered outputs are derived from the next state so they line up
    // with the state they describe.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (xfer) begin
                    if (!len_ok(bus.rx_data, DEPTH)) begin
                        state_d = ST_ERR;
                    end else begin
                        len_d      = (ADDR_W+1)'(bus.rx_data);
                        csum_d     = bus.rx_data;
                        cnt_d      = '0;
                        mem_addr_d = '0;
                        state_d    = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    csum_d = csum_q ^ bus.rx_data;
                    if (pk_word_valid) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cnt_q[ADDR_W-1:0];
                        mem_wdata_d = pk_word;
                        cnt_d       = cnt_inc;
                        if (cnt_inc == len_q) state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) state_d = (bus.rx_data == csum_q) ? ST_DONE : ST_ERR;
            end
            ST_DONE, ST_ERR: begin
                if (start) state_d = ST_LEN;
            end
            default: state_d = ST_IDLE;
        endcase

        rx_ready_d  = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERR);
        cpu_reset_d = (state_d != ST_DONE);
    end

    // State and output registers; reset takes priority over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            csum_q      <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            rx_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rx_ready_q  <= rx_ready_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_reset     = cpu_reset_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_loaded  = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a vector table of complete streams plus
// hand-written sequences for full image, start during DATA and reset mid-load.
module tb_imem_loader;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              cpu_reset;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [31:0]       wr_data_q [$];
    logic [31:0]       tb_mem [0:DEPTH-1];

    // Memory model and write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
            tb_mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    typedef struct {
        logic [79:0] stream;
        int          nbytes;
        logic        exp_done;
        logic        exp_err;
        int          exp_wl;
        int          exp_nwr;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; returns #1 after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        for (int i = 0; i < gap; i++) tick();
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (bus.rx_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (bus.rx_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL rx_ready_timeout: got 0, expected 1");
        end
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], (k == 0) ? gap : 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_ready"},  32'(bus.rx_ready),  32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset),     32'd1);
        check({tag, "_done"},      32'(done),          32'd0);
        check({tag, "_error"},     32'(error),         32'd0);
        check({tag, "_wl"},        32'(words_loaded),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] img [0:DEPTH-1];
        logic [7:0]  csum;
        logic [79:0] s;

        reset        = 1'b1;
        start        = 1'b0;
        bus.rx_data  = 8'd0;
        bus.rx_valid = 1'b0;

        // ---- reset held 3 cycles ----
        for (int i = 0; i < 3; i++) tick();
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_mem_wdata", bus.mem_wdata,      32'd0);
        check_idle_outputs("rst");
        reset = 1'b0;
        bus.rx_valid = 1'b1;   // valid alone must not open the port
        for (int i = 0; i < 3; i++) tick();
        check("idle_rx_ready", 32'(bus.rx_ready), 32'd0);
        bus.rx_valid = 1'b0;
        $display("reset: outputs at reset values, rx_ready held low without start");

        // ---- vector table ----
        vecs[0] = '{80'h43_00_50_01_13_01, 6, 1'b1, 1'b0, 1, 1, 32'h00500113, 32'h00500113};
        vecs[1] = '{80'h44_00_50_01_13_01, 6, 1'b0, 1'b1, 1, 1, 32'h00500113, 32'h00500113};
        vecs[2] = '{80'h43_00_50_01_13_01, 6, 1'b1, 1'b0, 1, 1, 32'h00500113, 32'h00500113};
        vecs[3] = '{80'h00,                1, 1'b0, 1'b1, 1, 0, 32'h0,        32'h0};
        vecs[4] = '{80'h21,                1, 1'b0, 1'b1, 1, 0, 32'h0,        32'h0};
        vecs[5] = '{80'h64_de_ad_be_ef_11_22_33_44_02, 10, 1'b1, 1'b0, 2, 2, 32'h11223344, 32'hdeadbeef};

        for (int i = 0; i < 6; i++) begin
            wr_addr_q.delete();
            wr_data_q.delete();
            pulse_start();
            check($sformatf("v%0d_start_rx_ready", i),  32'(bus.rx_ready), 32'd1);
            check($sformatf("v%0d_start_cpu_reset", i), 32'(cpu_reset),    32'd1);
            check($sformatf("v%0d_start_done", i),      32'(done),         32'd0);
            check($sformatf("v%0d_start_error", i),     32'(error),        32'd0);
            s = vecs[i].stream;
            for (int j = 0; j < vecs[i].nbytes; j++) send_byte(s[8*j +: 8], (j % 3 == 1) ? 2 : 0);
            check($sformatf("v%0d_done", i),      32'(done),            32'(vecs[i].exp_done));
            check($sformatf("v%0d_error", i),     32'(error),           32'(vecs[i].exp_err));
            check($sformatf("v%0d_cpu_reset", i), 32'(cpu_reset),       32'(!vecs[i].exp_done));
            check($sformatf("v%0d_rx_ready", i),  32'(bus.rx_ready),    32'd0);
            check($sformatf("v%0d_wl", i),        32'(words_loaded),    32'(vecs[i].exp_wl));
            check($sformatf("v%0d_nwr", i),       32'(wr_addr_q.size()), 32'(vecs[i].exp_nwr));
            if (vecs[i].exp_nwr > 0 && wr_addr_q.size() == vecs[i].exp_nwr) begin
                check($sformatf("v%0d_first_addr", i), 32'(wr_addr_q[0]), 32'd0);
                check($sformatf("v%0d_first_data", i), wr_data_q[0],      vecs[i].exp_first);
                check($sformatf("v%0d_last_addr", i),  32'(wr_addr_q[vecs[i].exp_nwr-1]), 32'(vecs[i].exp_nwr-1));
                check($sformatf("v%0d_last_data", i),  wr_data_q[vecs[i].exp_nwr-1],      vecs[i].exp_last);
            end
            $display("vector %0d: done=%0d error=%0d words_loaded=%0d writes=%0d",
                     i, done, error, words_loaded, wr_addr_q.size());
        end

        // ---- full 32-word image with random valid gaps ----
        wr_addr_q.delete();
        wr_data_q.delete();
        csum = 8'h20;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = 32'h9E3779B9 * 32'(i + 1);
            csum = csum ^ img[i][7:0] ^ img[i][15:8] ^ img[i][23:16] ^ img[i][31:24];
        end
        pulse_start();
        send_byte(8'h20, 0);
        for (int i = 0; i < DEPTH; i++) send_word(img[i], int'($urandom_range(0, 3)));
        send_byte(csum, int'($urandom_range(0, 3)));
        check("full_nwr",       32'(wr_addr_q.size()), 32'd32);
        check("full_wl",        32'(words_loaded),     32'd32);
        check("full_done",      32'(done),             32'd1);
        check("full_cpu_reset", 32'(cpu_reset),        32'd0);
        if (wr_addr_q.size() == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) begin
                check($sformatf("full_addr%0d", i), 32'(wr_addr_q[i]), 32'(i));
                check($sformatf("full_data%0d", i), wr_data_q[i],      img[i]);
            end
        end
        $display("full image: writes=%0d words_loaded=%0d done=%0d", wr_addr_q.size(), words_loaded, done);

        // ---- start pulsed during DATA is ignored ----
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h13, 0);
        send_byte(8'h01, 0);
        pulse_start();
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        send_byte(8'h43, 0);
        check("midstart_done",  32'(done),             32'd1);
        check("midstart_wl",    32'(words_loaded),     32'd1);
        check("midstart_nwr",   32'(wr_addr_q.size()), 32'd1);
        if (wr_data_q.size() == 1) check("midstart_data", wr_data_q[0], 32'h00500113);
        $display("start during DATA: done=%0d words_loaded=%0d", done, words_loaded);

        // ---- reset after two words ----
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h03, 0);
        send_word(32'hCAFE0001, 0);
        send_word(32'hCAFE0002, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("midrst");
        tick();
        check("midrst_rx_ready_hold", 32'(bus.rx_ready),    32'd0);
        check("midrst_nwr",           32'(wr_addr_q.size()), 32'd2);
        check("midrst_mem0",          tb_mem[0],            32'hCAFE0001);
        check("midrst_mem1",          tb_mem[1],            32'hCAFE0002);
        $display("reset mid-load: rx_ready=%0d writes=%0d mem0=%08h mem1=%08h",
                 bus.rx_ready, wr_addr_q.size(), tb_mem[0], tb_mem[1]);

        // ---- reset and start together: reset wins ----
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_rx_ready", 32'(bus.rx_ready), 32'd0);
        tick();
        check("rst_start_rx_ready2", 32'(bus.rx_ready), 32'd0);
        $display("reset with start: rx_ready=%0d", bus.rx_ready);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
